// File: rtl/xillybus_mem_bank_pkg.sv
// Shared definitions for the seekable Xillybus memory bank: end-of-memory modes
// and the clear/ready controller states.
package xillybus_mem_bank_pkg;

    localparam logic MEM_WRAP = 1'b1;
    localparam logic MEM_STOP = 1'b0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/xillybus_mem_bank_ram.sv
// Simple dual-port RAM: one write port and one registered read port, with no
// read-during-write bypass so that it maps onto plain block RAM.
module xillybus_mem_bank_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port, holds its value between reads
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/xillybus_mem_bank.sv
// Seekable memory endpoint for a Xillybus user_mem_* channel pair with separate
// auto-incrementing pointers, read-during-write bypass and sticky error flags.
module xillybus_mem_bank
    import xillybus_mem_bank_pkg::*;
#(
    parameter int   DATA_W    = 32,
    parameter int   ADDR_W    = 5,
    parameter logic WRAP      = 1'b1,
    parameter logic INIT_ZERO = 1'b1
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic              user_r_mem_rden,
    output logic [DATA_W-1:0] user_r_mem_data,
    output logic              user_r_mem_empty,
    output logic              user_r_mem_eof,
    input  logic              user_r_mem_open,
    input  logic              user_w_mem_wren,
    input  logic [DATA_W-1:0] user_w_mem_data,
    output logic              user_w_mem_full,
    input  logic              user_w_mem_open,
    input  logic [ADDR_W-1:0] user_mem_addr,
    input  logic              user_mem_addr_update,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    mem_state_e        state_r, state_nxt_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W:0]   rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic              r_open_d_r, w_open_d_r, open_rise_s;
    logic              ready_s, clearing_s, rd_ok_s, wr_ok_s;
    logic              empty_r, full_r, eof_r, err_ovf_r, err_udf_r;
    logic              byp_sel_r;
    logic [DATA_W-1:0] byp_data_r, ram_q_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;

    // In wrap mode the end flag never sets; in stop mode it marks one-past-last.
    function automatic logic [ADDR_W:0] ptr_inc(input logic [ADDR_W:0] p);
        if (WRAP == MEM_WRAP) begin
            ptr_inc = {1'b0, p[ADDR_W-1:0] + ADDR_ONE};
        end else begin
            ptr_inc = p + PTR_ONE;
        end
    endfunction

    assign ready_s     = (state_r == ST_READY);
    assign clearing_s  = (state_r == ST_CLEAR);
    assign rd_ok_s     = ready_s & user_r_mem_rden & ~empty_r;
    assign wr_ok_s     = ready_s & user_w_mem_wren & ~full_r;
    assign open_rise_s = (user_r_mem_open & ~r_open_d_r) | (user_w_mem_open & ~w_open_d_r);

    // controller state register
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            state_r <= (INIT_ZERO == 1'b1) ? ST_CLEAR : ST_READY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // controller next state: sweep every address once, then stay ready
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == ADDR_MAX) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = ST_CLEAR;
        endcase
    end

    // next pointers: accesses use the old pointers, seek beats open edge
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (user_mem_addr_update) begin
            rd_ptr_nxt_s = {1'b0, user_mem_addr};
            wr_ptr_nxt_s = {1'b0, user_mem_addr};
        end else if (open_rise_s) begin
            rd_ptr_nxt_s = '0;
            wr_ptr_nxt_s = '0;
        end else begin
            rd_ptr_nxt_s = rd_ok_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            wr_ptr_nxt_s = wr_ok_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        end
    end

    // RAM write port shared between the zero sweep and user writes
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_ptr_r[ADDR_W-1:0];
        ram_wdata_s = user_w_mem_data;
        if (clearing_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_cnt_r;
            ram_wdata_s = '0;
        end else begin
            ram_we_s    = wr_ok_s;
            ram_waddr_s = wr_ptr_r[ADDR_W-1:0];
            ram_wdata_s = user_w_mem_data;
        end
    end

    // pointers, open-edge history, flags, bypass capture and sticky errors
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            r_open_d_r <= 1'b0;
            w_open_d_r <= 1'b0;
            clr_cnt_r  <= '0;
            empty_r    <= INIT_ZERO;
            full_r     <= INIT_ZERO;
            eof_r      <= 1'b0;
            err_ovf_r  <= 1'b0;
            err_udf_r  <= 1'b0;
            byp_sel_r  <= 1'b1;
            byp_data_r <= '0;
        end else begin
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            r_open_d_r <= user_r_mem_open;
            w_open_d_r <= user_w_mem_open;
            if (clearing_s) begin
                clr_cnt_r <= clr_cnt_r + ADDR_ONE;
            end
            if (state_nxt_s == ST_CLEAR) begin
                empty_r <= 1'b1;
                full_r  <= 1'b1;
                eof_r   <= 1'b0;
            end else if (WRAP == MEM_WRAP) begin
                empty_r <= 1'b0;
                full_r  <= 1'b0;
                eof_r   <= 1'b0;
            end else begin
                empty_r <= rd_ptr_nxt_s[ADDR_W];
                full_r  <= wr_ptr_nxt_s[ADDR_W];
                eof_r   <= rd_ptr_nxt_s[ADDR_W];
            end
            err_ovf_r <= err_ovf_r | (user_w_mem_wren & full_r);
            err_udf_r <= err_udf_r | (user_r_mem_rden & empty_r);
            // byp_sel_r only moves on a read so the output holds between reads
            if (rd_ok_s) begin
                byp_sel_r  <= wr_ok_s & (rd_ptr_r == wr_ptr_r);
                byp_data_r <= user_w_mem_data;
            end
        end
    end

    xillybus_mem_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (bus_clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (rd_ok_s),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (ram_q_s)
    );

    assign user_r_mem_data  = byp_sel_r ? byp_data_r : ram_q_s;
    assign user_r_mem_empty = empty_r;
    assign user_r_mem_eof   = eof_r;
    assign user_w_mem_full  = full_r;
    assign err_overflow     = err_ovf_r;
    assign err_underflow    = err_udf_r;

endmodule

// File: tb/tb_xillybus_mem_bank.sv
// Bench driving a wrapping and a stopping instance with identical stimulus and
// comparing both against an array/integer model of the memory channel.
module tb_xillybus_mem_bank;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n, rden, wren, upd, ropen, wopen;
    logic [31:0] wdata;
    logic [4:0]  addr;

    logic [31:0] q   [2];
    logic        emp [2];
    logic        ful [2];
    logic        eof [2];
    logic        eo  [2];
    logic        eu  [2];

    logic [31:0] m_mem [2][DEPTH];
    int          m_rd  [2];
    int          m_wr  [2];
    logic [31:0] m_q   [2];
    logic        m_eo  [2];
    logic        m_eu  [2];
    int          m_clr;
    logic        m_ro_d, m_wo_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xillybus_mem_bank #(.DATA_W(32), .ADDR_W(5), .WRAP(1'b1), .INIT_ZERO(1'b1)) dut_wrap (
        .bus_clk(clk), .trn_reset_n(rst_n),
        .user_r_mem_rden(rden), .user_r_mem_data(q[0]), .user_r_mem_empty(emp[0]),
        .user_r_mem_eof(eof[0]), .user_r_mem_open(ropen),
        .user_w_mem_wren(wren), .user_w_mem_data(wdata), .user_w_mem_full(ful[0]),
        .user_w_mem_open(wopen), .user_mem_addr(addr), .user_mem_addr_update(upd),
        .err_overflow(eo[0]), .err_underflow(eu[0])
    );

    xillybus_mem_bank #(.DATA_W(32), .ADDR_W(5), .WRAP(1'b0), .INIT_ZERO(1'b1)) dut_stop (
        .bus_clk(clk), .trn_reset_n(rst_n),
        .user_r_mem_rden(rden), .user_r_mem_data(q[1]), .user_r_mem_empty(emp[1]),
        .user_r_mem_eof(eof[1]), .user_r_mem_open(ropen),
        .user_w_mem_wren(wren), .user_w_mem_data(wdata), .user_w_mem_full(ful[1]),
        .user_w_mem_open(wopen), .user_mem_addr(addr), .user_mem_addr_update(upd),
        .err_overflow(eo[1]), .err_underflow(eu[1])
    );

    // Reference behaviour for one clock edge, instance 0 wraps, instance 1 stops.
    task automatic model_edge();
        logic rise;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_rd[k] = 0; m_wr[k] = 0; m_q[k] = 32'h0;
                m_eo[k] = 1'b0; m_eu[k] = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 32'h0;
            end
            m_clr = DEPTH; m_ro_d = 1'b0; m_wo_d = 1'b0;
        end else begin
            rise = (ropen && !m_ro_d) || (wopen && !m_wo_d);
            for (int k = 0; k < 2; k++) begin
                bit wrapk, ready, e, f;
                wrapk = (k == 0);
                ready = (m_clr == 0);
                e = !ready || (!wrapk && m_rd[k] == DEPTH);
                f = !ready || (!wrapk && m_wr[k] == DEPTH);
                if (rden) begin
                    if (e) m_eu[k] = 1'b1;
                    else begin
                        m_q[k] = (wren && !f && m_rd[k] == m_wr[k]) ? wdata : m_mem[k][m_rd[k]];
                        m_rd[k] = wrapk ? (m_rd[k] + 1) % DEPTH : m_rd[k] + 1;
                    end
                end
                if (wren) begin
                    if (f) m_eo[k] = 1'b1;
                    else begin
                        m_mem[k][m_wr[k]] = wdata;
                        m_wr[k] = wrapk ? (m_wr[k] + 1) % DEPTH : m_wr[k] + 1;
                    end
                end
                if (upd) begin
                    m_rd[k] = int'(addr); m_wr[k] = int'(addr);
                end else if (rise) begin
                    m_rd[k] = 0; m_wr[k] = 0;
                end
            end
            m_ro_d = ropen; m_wo_d = wopen;
            if (m_clr > 0) m_clr--;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit wrapk, ready;
            wrapk = (k == 0);
            ready = (m_clr == 0);
            chk($sformatf("data%0d", k), q[k], m_q[k]);
            chk($sformatf("empty%0d", k), {31'h0, emp[k]},
                {31'h0, !ready || (!wrapk && m_rd[k] == DEPTH)});
            chk($sformatf("full%0d", k), {31'h0, ful[k]},
                {31'h0, !ready || (!wrapk && m_wr[k] == DEPTH)});
            chk($sformatf("eof%0d", k), {31'h0, eof[k]},
                {31'h0, ready && !wrapk && m_rd[k] == DEPTH});
            chk($sformatf("ovf%0d", k), {31'h0, eo[k]}, {31'h0, m_eo[k]});
            chk($sformatf("udf%0d", k), {31'h0, eu[k]}, {31'h0, m_eu[k]});
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] d,
                        input logic u, input logic [4:0] a);
        rden = r; wren = w; wdata = d; upd = u; addr = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; rden = 1'b0; wren = 1'b0; upd = 1'b0;
        ropen = 1'b0; wopen = 1'b0; wdata = 32'h0; addr = 5'd0;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
        rst_n = 1'b1;
        repeat (34) step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
        // cleared contents read back as zero
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd0);
        repeat (DEPTH) step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        // seek, write three, seek back, read three
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd3);
        step(1'b0, 1'b1, 32'h0000_00A1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 32'h0000_00A2, 1'b0, 5'd0);
        step(1'b0, 1'b1, 32'h0000_00A3, 1'b0, 5'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd3);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        // end of memory: stop instance reaches eof, third read underflows
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd30);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        // write across the top address, then read it back
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd31);
        step(1'b0, 1'b1, 32'h0000_00B0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 32'h0000_00B1, 1'b0, 5'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd31);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        // read-during-write at the same pointer
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd7);
        step(1'b1, 1'b1, 32'h0000_00C7, 1'b0, 5'd0);
        // open edge together with a seek, then open edge alone
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd12);
        ropen = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd5);
        step(1'b1, 1'b1, 32'h0000_00E5, 1'b0, 5'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        ropen = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd12);
        ropen = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 32'h0000_00E0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) ropen = ~ropen;
            if ($urandom_range(0, 19) == 0) wopen = ~wopen;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
        end
        // reset in the middle of traffic restarts the sweep
        rst_n = 1'b0;
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 5'd0);
        rst_n = 1'b1;
        ropen = 1'b0; wopen = 1'b0;
        repeat (10) step(1'b1, 1'b1, $urandom, 1'b0, 5'd0);
        repeat (26) step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
